// File: rtl/adc_dual_serial_capture.sv
// adc_dual_serial_capture
//
// Capture front end for two AD7276-class serial ADCs (one per scope channel).
// Both converters share a single SCLK / CS_n pair; each start request runs one
// 16-clock conversion frame. The two serial words are deserialised MSB-first
// and the 12 data bits of each are presented on data_0 / data_1 together with
// a one-cycle data_rdy strobe. Feeds the Sampling block directly.
//
// Parameters
//    CLK_DIV      : SCLK half-period in CLK100MHz cycles (1..255)
//    QUIET_CYCLES : minimum CS_n high time between frames (1..255)
//
// Ports
//    CLK100MHz : system clock, the only clock in the block
//    rst       : asynchronous active-high reset
//    en_0/en_1 : channel enables, latched at frame start
//    start     : single-cycle conversion request
//    sdata_0/1 : serial data from ADC 0 / ADC 1
//    ovr_clr   : clears the sticky overrun flag
//    sclk      : shared ADC serial clock, idles high
//    cs_n      : shared ADC chip select, active low
//    busy      : high whenever the FSM is not idle
//    data_0/1  : last captured 12-bit sample per channel
//    data_rdy  : one-cycle strobe marking new data
//    overrun   : sticky flag for a start rejected while busy
//
// Optional feature macro: ADC_CAPTURE_OVERRUN_EN
//    defined     -> overrun flag logic is built
//    not defined -> overrun is tied low and ovr_clr is ignored

module adc_dual_serial_capture #(
   parameter int CLK_DIV      = 2,
   parameter int QUIET_CYCLES = 4
) (
   input  logic        CLK100MHz,
   input  logic        rst,
   input  logic        en_0,
   input  logic        en_1,
   input  logic        start,
   input  logic        sdata_0,
   input  logic        sdata_1,
   input  logic        ovr_clr,
   output logic        sclk,
   output logic        cs_n,
   output logic        busy,
   output logic [11:0] data_0,
   output logic [11:0] data_1,
   output logic        data_rdy,
   output logic        overrun
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      QUIET = 2'd2
   } state_t;

   localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
   localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
   // 16 falling + 16 rising SCLK edges make up one frame
   localparam logic [5:0] EDGES_PER_FRAME = 6'd32;

   state_t      state;
   logic [7:0]  div_cnt;
   logic [7:0]  quiet_cnt;
   logic [5:0]  edge_cnt;
   logic [15:0] shift_0;
   logic [15:0] shift_1;
   logic        en_lat_0;
   logic        en_lat_1;

   // Frame sequencer. SCLK is generated from a half-period divider and each
   // toggle is counted; a capture happens on the same clock edge that drives
   // the SCLK register from 0 to 1, so the ADC has had a full half-period
   // since its falling-edge update. Once all 32 edges have been produced the
   // next cycle unloads the shift registers, so the final captured bit is
   // already in place when data_x is loaded.
   always_ff @(posedge CLK100MHz or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sclk      <= 1'b1;
         cs_n      <= 1'b1;
         busy      <= 1'b0;
         data_0    <= 12'h000;
         data_1    <= 12'h000;
         data_rdy  <= 1'b0;
         div_cnt   <= 8'd0;
         quiet_cnt <= 8'd0;
         edge_cnt  <= 6'd0;
         shift_0   <= 16'h0000;
         shift_1   <= 16'h0000;
         en_lat_0  <= 1'b0;
         en_lat_1  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               data_rdy <= 1'b0;
               if (start && (en_0 || en_1)) begin
                  state    <= CONV;
                  cs_n     <= 1'b0;
                  sclk     <= 1'b1;
                  busy     <= 1'b1;
                  en_lat_0 <= en_0;
                  en_lat_1 <= en_1;
                  div_cnt  <= 8'd0;
                  edge_cnt <= 6'd0;
                  shift_0  <= 16'h0000;
                  shift_1  <= 16'h0000;
               end
            end

            CONV: begin
               if (edge_cnt == EDGES_PER_FRAME) begin
                  // Keep only the 12 data bits; the ADC frames them with two
                  // leading and two trailing zeros.
                  state     <= QUIET;
                  cs_n      <= 1'b1;
                  sclk      <= 1'b1;
                  data_rdy  <= 1'b1;
                  data_0    <= en_lat_0 ? shift_0[13:2] : 12'h000;
                  data_1    <= en_lat_1 ? shift_1[13:2] : 12'h000;
                  quiet_cnt <= 8'd0;
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt  <= 8'd0;
                  sclk     <= ~sclk;
                  edge_cnt <= edge_cnt + 6'd1;
                  if (!sclk) begin
                     shift_0 <= {shift_0[14:0], sdata_0};
                     shift_1 <= {shift_1[14:0], sdata_1};
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            QUIET: begin
               data_rdy <= 1'b0;
               if (quiet_cnt == QUIET_LAST) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  quiet_cnt <= 8'd0;
               end else begin
                  quiet_cnt <= quiet_cnt + 8'd1;
               end
            end

            default: begin
               state    <= IDLE;
               sclk     <= 1'b1;
               cs_n     <= 1'b1;
               busy     <= 1'b0;
               data_rdy <= 1'b0;
            end
         endcase
      end
   end

   // The MSB of each frame is a framing zero that is shifted out and never
   // used; it is collected here only so it is visibly consumed.
   logic unused_shift_msb;
   assign unused_shift_msb = shift_0[15] | shift_1[15];

`ifdef ADC_CAPTURE_OVERRUN_EN
   // Sticky overrun: a start that arrives while a frame (or its quiet gap)
   // is in progress is dropped and flagged. Set has priority over clear so
   // a rejected start is never lost.
   always_ff @(posedge CLK100MHz or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (start && (en_0 || en_1) && (state != IDLE)) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end
`else
   assign overrun = 1'b0;

   logic unused_ovr_clr;
   assign unused_ovr_clr = ovr_clr;
`endif

endmodule

// File: tb/tb_adc_dual_serial_capture.sv
// tb_adc_dual_serial_capture
//
// Two copies of adc_dual_serial_capture share the control inputs: lane 0 uses
// the default CLK_DIV of 2, lane 1 uses CLK_DIV of 1. Each lane has its own
// ADC model that shifts out a 16-bit word MSB-first after every falling SCLK
// edge. A frame model decides which starts each lane accepts and pushes the
// expected data_rdy cycle and samples into that lane's queue; a per-lane
// monitor pops and compares whenever data_rdy is seen.

module tb_adc_dual_serial_capture;

   localparam int QC   = 4;
   localparam int CD0  = 2;
   localparam int CD1  = 1;
   localparam int LAT0 = 2 + 32 * CD0;
   localparam int LAT1 = 2 + 32 * CD1;

`ifdef ADC_CAPTURE_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   typedef struct {
      int          cycle;
      logic [11:0] d0;
      logic [11:0] d1;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_0 = 1'b0;
   logic        en_1 = 1'b0;
   logic        start = 1'b0;
   logic        ovr_clr = 1'b0;
   logic [15:0] word_0 = 16'h0000;
   logic [15:0] word_1 = 16'h0000;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int busy_until[2] = '{0, 0};
   bit exp_ovr[2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Every comparison funnels through here so the counts stay in one place.
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int CD = (g == 0) ? CD0 : CD1;

      logic        sclk;
      logic        cs_n;
      logic        busy;
      logic        data_rdy;
      logic        overrun;
      logic [11:0] data_0;
      logic [11:0] data_1;
      logic        sdata_0 = 1'b0;
      logic        sdata_1 = 1'b0;

      exp_t        q[$];
      exp_t        e_mon;
      logic [15:0] w0 = 16'h0000;
      logic [15:0] w1 = 16'h0000;
      int          idx = -1;
      int          rises = 0;
      int          idle_edges = 0;
      int          rdy_cyc = 0;
      bit          rdy_seen = 1'b0;
      logic        prev_sclk = 1'b1;
      logic        prev_cs = 1'b1;
      logic        prev_busy = 1'b0;

      adc_dual_serial_capture #(
         .CLK_DIV      (CD),
         .QUIET_CYCLES (QC)
      ) dut (
         .CLK100MHz (clk),
         .rst       (rst),
         .en_0      (en_0),
         .en_1      (en_1),
         .start     (start),
         .sdata_0   (sdata_0),
         .sdata_1   (sdata_1),
         .ovr_clr   (ovr_clr),
         .sclk      (sclk),
         .cs_n      (cs_n),
         .busy      (busy),
         .data_0    (data_0),
         .data_1    (data_1),
         .data_rdy  (data_rdy),
         .overrun   (overrun)
      );

      // ADC model: latch the conversion word when CS_n falls, then present
      // one bit per falling SCLK edge, MSB first.
      always @(negedge cs_n) begin
         w0  = word_0;
         w1  = word_1;
         idx = 15;
      end

      always @(negedge sclk) begin
         if (!cs_n && idx >= 0) begin
            sdata_0 = w0[idx];
            sdata_1 = w1[idx];
            idx--;
         end
      end

      // Monitor: count capture edges per frame, score every data_rdy and
      // check the quiet gap that follows it.
      always @(negedge clk) begin
         if (rst) begin
            rises    = 0;
            rdy_seen = 1'b0;
         end else begin
            if (prev_cs && !cs_n) rises = 0;
            if (!prev_sclk && sclk && !cs_n) rises++;
            if (!busy && (sclk !== prev_sclk)) idle_edges++;
            if (data_rdy) begin
               if (q.size() == 0) begin
                  checkOutput($sformatf("lane%0d unexpected_rdy", g), 32'(data_rdy), 32'd0);
               end else begin
                  e_mon = q.pop_front();
                  checkOutput($sformatf("lane%0d rdy_cycle", g), 32'(cyc), 32'(e_mon.cycle));
                  checkOutput($sformatf("lane%0d data_0", g), 32'(data_0), 32'(e_mon.d0));
                  checkOutput($sformatf("lane%0d data_1", g), 32'(data_1), 32'(e_mon.d1));
                  checkOutput($sformatf("lane%0d sclk_rises", g), 32'(rises), 32'd16);
               end
               rdy_seen = 1'b1;
               rdy_cyc  = cyc;
            end
            if (prev_busy && !busy && rdy_seen) begin
               checkOutput($sformatf("lane%0d quiet_gap", g), 32'(cyc - rdy_cyc), 32'(QC));
               rdy_seen = 1'b0;
            end
         end
         prev_sclk = sclk;
         prev_cs   = cs_n;
         prev_busy = busy;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Issue one start pulse. The frame model accepts it on a lane only when
   // that lane's previous frame, including its quiet gap, is over; otherwise
   // an enabled start is recorded as an overrun.
   task automatic applyStimulus(input bit e0, input bit e1, input logic [11:0] s0,
                                input logic [11:0] s1, input bit junk_pads);
      exp_t e;
      int   lat;
      @(negedge clk);
      en_0   = e0;
      en_1   = e1;
      word_0 = {(junk_pads ? 2'($urandom) : 2'b00), s0, (junk_pads ? 2'($urandom) : 2'b00)};
      word_1 = {(junk_pads ? 2'($urandom) : 2'b00), s1, (junk_pads ? 2'($urandom) : 2'b00)};
      start  = 1'b1;
      for (int g = 0; g < 2; g++) begin
         lat = (g == 0) ? LAT0 : LAT1;
         if (e0 || e1) begin
            if (cyc >= busy_until[g]) begin
               e.cycle = cyc + lat;
               e.d0    = e0 ? s0 : 12'h000;
               e.d1    = e1 ? s1 : 12'h000;
               if (g == 0) lane[0].q.push_back(e);
               else        lane[1].q.push_back(e);
               busy_until[g] = cyc + lat + QC;
            end else begin
               exp_ovr[g] = OVR_EN;
            end
         end
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("lane0 overrun", 32'(lane[0].overrun), 32'(exp_ovr[0]));
      checkOutput("lane1 overrun", 32'(lane[1].overrun), 32'(exp_ovr[1]));
   endtask

   task automatic clearOverrun();
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr    = 1'b0;
      exp_ovr[0] = 1'b0;
      exp_ovr[1] = 1'b0;
      checkOutput("lane0 overrun_clr", 32'(lane[0].overrun), 32'd0);
      checkOutput("lane1 overrun_clr", 32'(lane[1].overrun), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " lane0 sclk"}, 32'(lane[0].sclk), 32'd1);
      checkOutput({tag, " lane0 cs_n"}, 32'(lane[0].cs_n), 32'd1);
      checkOutput({tag, " lane0 busy"}, 32'(lane[0].busy), 32'd0);
      checkOutput({tag, " lane0 data_rdy"}, 32'(lane[0].data_rdy), 32'd0);
      checkOutput({tag, " lane0 overrun"}, 32'(lane[0].overrun), 32'd0);
      checkOutput({tag, " lane0 data"}, 32'({lane[0].data_1, lane[0].data_0}), 32'd0);
      checkOutput({tag, " lane1 sclk"}, 32'(lane[1].sclk), 32'd1);
      checkOutput({tag, " lane1 cs_n"}, 32'(lane[1].cs_n), 32'd1);
      checkOutput({tag, " lane1 busy"}, 32'(lane[1].busy), 32'd0);
      checkOutput({tag, " lane1 data_rdy"}, 32'(lane[1].data_rdy), 32'd0);
      checkOutput({tag, " lane1 overrun"}, 32'(lane[1].overrun), 32'd0);
      checkOutput({tag, " lane1 data"}, 32'({lane[1].data_1, lane[1].data_0}), 32'd0);
   endtask

   // Bounded wait until both lanes are idle and every queued frame is done.
   task automatic waitIdle();
      int n;
      n = 0;
      while ((lane[0].busy || lane[1].busy || cyc < busy_until[0] || cyc < busy_until[1]
              || lane[0].q.size() != 0 || lane[1].q.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("lane0 idle", 32'(lane[0].busy), 32'd0);
      checkOutput("lane1 idle", 32'(lane[1].busy), 32'd0);
   endtask

   initial begin
      bit e0;
      bit e1;

      // Reset held, then released with no start: the bus must stay quiet.
      rst = 1'b1;
      waitCycles(3);
      checkResetState("reset");
      rst = 1'b0;
      waitCycles(12);
      checkOutput("lane0 idle_edges", 32'(lane[0].idle_edges), 32'd0);
      checkOutput("lane1 idle_edges", 32'(lane[1].idle_edges), 32'd0);
      checkOutput("lane0 idle_cs_n", 32'(lane[0].cs_n), 32'd1);

      // Directed frames: both channels, then channel 1 disabled.
      applyStimulus(1'b1, 1'b1, 12'hABC, 12'h123, 1'b0);
      waitIdle();
      applyStimulus(1'b1, 1'b0, 12'hABC, 12'h123, 1'b0);
      waitIdle();

      // Both enables low: the start is ignored.
      applyStimulus(1'b0, 1'b0, 12'h5A5, 12'hA5A, 1'b0);
      waitCycles(10);
      checkOutput("lane0 disabled_cs_n", 32'(lane[0].cs_n), 32'd1);
      checkOutput("lane1 disabled_cs_n", 32'(lane[1].cs_n), 32'd1);
      checkOutput("lane0 disabled_busy", 32'(lane[0].busy), 32'd0);

      // A second start at cycle 10 of a running frame is rejected.
      applyStimulus(1'b1, 1'b1, 12'h3C7, 12'hE18, 1'b0);
      waitCycles(8);
      applyStimulus(1'b1, 1'b1, 12'hFFF, 12'hFFF, 1'b0);
      clearOverrun();
      waitIdle();

      // Reset at cycle 20 of a frame: outputs drop at once, no data_rdy.
      applyStimulus(1'b1, 1'b1, 12'h777, 12'h888, 1'b0);
      waitCycles(19);
      lane[0].q.delete();
      lane[1].q.delete();
      busy_until[0] = 0;
      busy_until[1] = 0;
      exp_ovr[0]    = 1'b0;
      exp_ovr[1]    = 1'b0;
      rst = 1'b1;
      #1;
      checkResetState("midframe_reset");
      waitCycles(3);
      rst = 1'b0;
      waitCycles(80);

      // Randomised frames, with occasional starts while busy.
      for (int i = 0; i < 25; i++) begin
         waitIdle();
         waitCycles($urandom_range(0, 4));
         e0 = ($urandom_range(0, 3) != 0);
         e1 = ($urandom_range(0, 3) != 0);
         applyStimulus(e0, e1, 12'($urandom), 12'($urandom), 1'b1);
         if ($urandom_range(0, 2) == 0) begin
            waitCycles($urandom_range(0, 40));
            applyStimulus(1'b1, 1'($urandom), 12'($urandom), 12'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 0) clearOverrun();
         end
      end
      waitIdle();
      clearOverrun();

      checkOutput("lane0 queue_drained", 32'(lane[0].q.size()), 32'd0);
      checkOutput("lane1 queue_drained", 32'(lane[1].q.size()), 32'd0);
      checkOutput("lane0 final_idle_edges", 32'(lane[0].idle_edges), 32'd0);
      checkOutput("lane1 final_idle_edges", 32'(lane[1].idle_edges), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
